// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the instruction fetch slice.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush and occupancy count; head word reads as zero when empty.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the head slot this cycle, so push is accepted even when full.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction prefetcher: credit-limited in-order memory requests feeding a
// small FIFO, with redirect handling that drains responses of the old stream.
module ifetch_unit
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int FIFO_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(FIFO_DEPTH);

    fetch_state_t          state;
    fetch_state_t          state_nxt;
    logic [DATA_WIDTH-1:0] fetch_pc;
    logic [DATA_WIDTH-1:0] rsp_pc;
    logic [DATA_WIDTH-1:0] target_pc;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         drop_cnt;
    logic [CW-1:0]         out_after_rsp;
    logic [CW-1:0]         drop_nxt;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  req_xfer;
    fetch_entry_t          push_entry;
    fetch_entry_t          head_entry;

    assign target_pc     = align_word(redirect_pc);
    assign out_after_rsp = outstanding - CW'(imem_rsp_valid);
    assign drop_nxt      = drop_cnt - CW'(imem_rsp_valid);
    assign req_xfer      = imem_req_valid && imem_req_ready;
    assign fifo_pop      = instr_valid && instr_ready;
    assign imem_req_addr = fetch_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: if (redirect_valid && out_after_rsp != '0) state_nxt = DRAIN;
            DRAIN: if (drop_nxt == '0) state_nxt = FETCH;
        endcase
    end

    // Credits count both buffered entries and in-flight requests so every
    // response is guaranteed a FIFO slot.
    always_comb begin
        imem_req_valid = 1'b0;
        fifo_push      = 1'b0;
        instr_valid    = 1'b0;
        if (state == FETCH && !reset) begin
            imem_req_valid = !redirect_valid &&
                             (({1'b0, fifo_count} + {1'b0, outstanding}) < CREDITS);
            fifo_push      = imem_rsp_valid;
            instr_valid    = !fifo_empty;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_xfer) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
            end else begin
                if (req_xfer)  fetch_pc <= fetch_pc + DATA_WIDTH'(4);
                if (fifo_push) rsp_pc   <= rsp_pc + DATA_WIDTH'(4);
            end
            if (state == FETCH) drop_cnt <= redirect_valid ? out_after_rsp : '0;
            else                drop_cnt <= drop_nxt;
        end
    end

    assign push_entry.pc    = rsp_pc;
    assign push_entry.instr = imem_rsp_data;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head_data (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign instr    = head_entry.instr;
    assign instr_pc = head_entry.pc;

    a_rsp_has_credit: assert property (@(posedge clk) disable iff (reset)
        imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with an in-order instruction memory model
// returning ~addr as the instruction word.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mem_rsp_en;
    logic [31:0] pend[$];
    logic [31:0] req_log[$];

    ifetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic do_reset(input bit rdy, input bit rsp_en);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        instr_ready    = rdy;
        mem_rsp_en     = rsp_en;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Memory: accepts at the edge, answers in the following cycle when enabled.
    initial begin
        logic        acc;
        logic [31:0] acc_addr;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            acc      = imem_req_valid && imem_req_ready;
            acc_addr = imem_req_addr;
            @(posedge clk);
            #2;
            if (reset) begin
                pend.delete();
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end else begin
                if (acc) pend.push_back(acc_addr);
                if (mem_rsp_en && pend.size() > 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = ~pend.pop_front();
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data  = '0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        mem_rsp_en     = 1'b1;
        repeat (2) @(posedge clk);
        half();
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_instr_pc", instr_pc, 32'h0);

        // Streaming
        @(posedge clk);
        #1;
        reset = 1'b0;
        half();
        check_eq("first_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("first_req_addr", imem_req_addr, 32'h0);
        cyc(); half(); cyc();
        for (int i = 0; i < 8; i++) begin
            half();
            check_eq("stream_pc", instr_pc, 32'(4 * i));
            check_eq("stream_instr", instr, ~32'(4 * i));
            cyc();
        end
        imem_req_ready = 1'b0;
        half();
        check_eq("stall_valid0", 32'(imem_req_valid), 32'd1);
        check_eq("stall_addr0", imem_req_addr, 32'h28);
        cyc(); half();
        check_eq("stall_valid1", 32'(imem_req_valid), 32'd1);
        check_eq("stall_addr1", imem_req_addr, 32'h28);

        // Backpressure
        do_reset(1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            half();
            if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
            cyc();
        end
        check_eq("bp_req_count", 32'(req_log.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            check_eq("bp_req_addr", (k < req_log.size()) ? req_log[k] : 32'hDEAD_BEEF, 32'(4 * k));
        instr_ready = 1'b1;
        half();
        check_eq("bp_full_no_req", 32'(imem_req_valid), 32'd0);
        check_eq("bp_head_pc", instr_pc, 32'h0);
        cyc(); half();
        check_eq("bp_resume_valid", 32'(imem_req_valid), 32'd1);
        check_eq("bp_resume_addr", imem_req_addr, 32'h10);
        check_eq("bp_next_pc", instr_pc, 32'h4);

        // Redirect with two outstanding
        do_reset(1'b1, 1'b0);
        half(); cyc(); half(); cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        half();
        check_eq("rd_req_gated", 32'(imem_req_valid), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        mem_rsp_en     = 1'b1;
        for (int c = 3; c < 5; c++) begin
            half();
            check_eq("rd_drain_no_req", 32'(imem_req_valid), 32'd0);
            check_eq("rd_drain_no_instr", 32'(instr_valid), 32'd0);
            cyc();
        end
        half();
        check_eq("rd_new_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("rd_new_req_addr", imem_req_addr, 32'h100);
        check_eq("rd_no_old_instr", 32'(instr_valid), 32'd0);
        cyc(); half();
        check_eq("rd_no_old_instr2", 32'(instr_valid), 32'd0);
        cyc(); half();
        check_eq("rd_first_pc", instr_pc, 32'h100);
        check_eq("rd_first_instr", instr, ~32'h100);

        // Unaligned redirect in the same cycle as a pop
        do_reset(1'b0, 1'b1);
        half(); cyc(); half(); cyc(); half(); cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h202;
        instr_ready    = 1'b1;
        half();
        check_eq("ua_pop_pc", instr_pc, 32'h0);
        check_eq("ua_req_gated", 32'(imem_req_valid), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        half();
        check_eq("ua_fifo_empty", 32'(instr_valid), 32'd0);
        check_eq("ua_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("ua_req_addr", imem_req_addr, 32'h200);
        cyc(); half(); cyc(); half();
        check_eq("ua_first_pc", instr_pc, 32'h200);
        check_eq("ua_first_instr", instr, ~32'h200);

        // Second redirect while draining
        do_reset(1'b1, 1'b0);
        half(); cyc(); half(); cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        half(); cyc();
        redirect_pc    = 32'h300;
        half();
        check_eq("dd_req_gated", 32'(imem_req_valid), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        mem_rsp_en     = 1'b1;
        for (int c = 4; c < 6; c++) begin
            half();
            check_eq("dd_drain_no_req", 32'(imem_req_valid), 32'd0);
            check_eq("dd_drain_no_instr", 32'(instr_valid), 32'd0);
            cyc();
        end
        half();
        check_eq("dd_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("dd_req_addr", imem_req_addr, 32'h300);
        cyc(); half(); cyc(); half();
        check_eq("dd_first_pc", instr_pc, 32'h300);

        // Asynchronous reset with three outstanding
        do_reset(1'b0, 1'b1);
        half(); cyc(); half(); cyc();
        mem_rsp_en = 1'b0;
        half(); cyc(); half(); cyc();
        half();
        check_eq("ar_pre_valid", 32'(instr_valid), 32'd1);
        check_eq("ar_pre_req", 32'(imem_req_valid), 32'd0);
        #1;
        reset = 1'b1;
        #1;
        check_eq("ar_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("ar_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("ar_instr", instr, 32'h0);
        check_eq("ar_instr_pc", instr_pc, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset      = 1'b0;
        mem_rsp_en = 1'b1;
        half();
        check_eq("ar_first_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("ar_first_req_addr", imem_req_addr, 32'h0);
        cyc(); half(); cyc(); half();
        check_eq("ar_first_pc", instr_pc, 32'h0);
        check_eq("ar_first_instr", instr, ~32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
